// File: rtl/bpu_update_gen_if.sv
// Shared types and the EX-to-BPU-update bus used by bpu_update_gen.
// The master side presents resolved instructions and consumes the update
// bundle; the slave side is the update generator itself.

`ifndef _LPHT_ADDR_WIDTH
`define _LPHT_ADDR_WIDTH 8
`endif
`ifndef _PC_RELATIVE
`define _PC_RELATIVE 2'd0
`endif
`ifndef _CALL
`define _CALL 2'd1
`endif
`ifndef _RETURN
`define _RETURN 2'd2
`endif

package bpu_update_gen_pkg;
    localparam int unsigned LphtW = `_LPHT_ADDR_WIDTH;

    typedef struct packed {
        logic             fsc;
        logic             taken;
        logic [29:0]      npc;
        logic [1:0]       lphr;
        logic [LphtW-1:0] lphr_index;
    } bpu_predict_t;

    typedef struct packed {
        logic             flush;
        logic [29:0]      br_target;
        logic [29:0]      pc;
        logic [1:0]       br_type;
        logic             br_taken;
        logic             btb_update;
        logic             lpht_update;
        logic [1:0]       lphr;
        logic [LphtW-1:0] lphr_index;
    } bpu_update_t;
endpackage

interface bpu_update_gen_if;
    import bpu_update_gen_pkg::*;

    logic         stall_i;
    logic         flush_i;
    logic         valid_i;
    logic [29:0]  pc_i;
    bpu_predict_t predict_i;
    logic         is_branch_i;
    logic [1:0]   br_type_i;
    logic         br_taken_i;
    logic [29:0]  br_target_i;
    bpu_update_t  update_o;
    logic         mispredict_o;
    logic [31:0]  perf_br_cnt_o;
    logic [31:0]  perf_mis_cnt_o;

    modport master (
        output stall_i, flush_i, valid_i, pc_i, predict_i, is_branch_i, br_type_i,
               br_taken_i, br_target_i,
        input  update_o, mispredict_o, perf_br_cnt_o, perf_mis_cnt_o
    );

    modport slave (
        input  stall_i, flush_i, valid_i, pc_i, predict_i, is_branch_i, br_type_i,
               br_taken_i, br_target_i,
        output update_o, mispredict_o, perf_br_cnt_o, perf_mis_cnt_o
    );
endinterface

// File: rtl/bpu_update_gen.sv
// bpu_update_gen: turns resolved EX-stage branches into the BPU update bundle.
// Detects mispredictions, raises a one-cycle flush with the correct target,
// produces BTB/LPHT training writes and discards wrong-path resolutions while
// waiting for the redirected stream (bounded by SHADOW_MAX cycles).
// Optional performance counters are enabled by defining BPU_UPD_PERF_EN.

`ifndef _LPHT_ADDR_WIDTH
`define _LPHT_ADDR_WIDTH 8
`endif
`ifndef _PC_RELATIVE
`define _PC_RELATIVE 2'd0
`endif

module bpu_update_gen #(
    parameter int unsigned LPHT_W     = `_LPHT_ADDR_WIDTH,
    parameter int unsigned SHADOW_MAX = 15
) (
    input logic            clk,
    input logic            rst_n,
    bpu_update_gen_if.slave bus
);

    localparam int unsigned CntW = $clog2(SHADOW_MAX + 1);
    localparam logic [CntW-1:0] CntMax = CntW'(SHADOW_MAX);

    typedef enum logic [0:0] {StRun, StShadow} state_e;

    state_e            state_q, state_d;
    logic [CntW-1:0]   cnt_q, cnt_d;
    logic [29:0]       shadow_tgt_q, shadow_tgt_d;

    logic              hit;
    logic              acc;
    logic              mis;
    logic [29:0]       act_npc;

    // Registered update bundle, kept as separate flops and packed on output.
    logic              flush_q;
    logic [29:0]       br_target_q;
    logic [29:0]       pc_q;
    logic [1:0]        br_type_q;
    logic              br_taken_q;
    logic              btb_update_q;
    logic              lpht_update_q;
    logic [1:0]        lphr_q;
    logic [LPHT_W-1:0] lphr_index_q;

    // Prediction metadata fields that training does not consume.
    logic              unused_pred;
    assign unused_pred = bus.predict_i.fsc ^ bus.predict_i.taken;

    // Two-bit saturating counter step.
    function automatic logic [1:0] sat2(input logic [1:0] cur, input logic taken);
        if (taken) begin
            return (cur == 2'b11) ? cur : cur + 2'd1;
        end
        return (cur == 2'b00) ? cur : cur - 2'd1;
    endfunction

    assign hit     = (state_q == StShadow) && (bus.pc_i == shadow_tgt_q);
    assign acc     = bus.valid_i && !bus.stall_i && !bus.flush_i &&
                     ((state_q == StRun) || hit);
    assign act_npc = (bus.is_branch_i && bus.br_taken_i) ? bus.br_target_i
                                                          : bus.pc_i + 30'd1;
    assign mis     = bus.is_branch_i && (act_npc != bus.predict_i.npc);

    // Next state: flush wins, then a fresh mispredict, then shadow hit/timeout.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        shadow_tgt_d = shadow_tgt_q;
        if (bus.flush_i) begin
            state_d = StRun;
            cnt_d   = '0;
        end else if (acc && mis) begin
            state_d      = StShadow;
            shadow_tgt_d = act_npc;
            cnt_d        = '0;
        end else begin
            unique case (state_q)
                StRun: begin
                    state_d = StRun;
                end
                StShadow: begin
                    if (acc) begin
                        state_d = StRun;
                    end else if (cnt_q == CntMax) begin
                        // Timeout: give up waiting; this cycle's input is dropped.
                        state_d = StRun;
                    end else if (!bus.stall_i) begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                default: begin
                    state_d = StRun;
                end
            endcase
        end
    end

    // FSM, shadow counter and redirect target registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= StRun;
            cnt_q        <= '0;
            shadow_tgt_q <= '0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            shadow_tgt_q <= shadow_tgt_d;
        end
    end

    // Update bundle: strobes pulse only after an accept, data holds otherwise.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            flush_q       <= 1'b0;
            br_target_q   <= '0;
            pc_q          <= '0;
            br_type_q     <= '0;
            br_taken_q    <= 1'b0;
            btb_update_q  <= 1'b0;
            lpht_update_q <= 1'b0;
            lphr_q        <= '0;
            lphr_index_q  <= '0;
        end else begin
            flush_q       <= acc && mis;
            btb_update_q  <= acc && bus.is_branch_i && bus.br_taken_i && mis;
            lpht_update_q <= acc && bus.is_branch_i && (bus.br_type_i == `_PC_RELATIVE);
            if (acc) begin
                br_target_q  <= act_npc;
                pc_q         <= bus.pc_i;
                br_type_q    <= bus.br_type_i;
                br_taken_q   <= bus.br_taken_i;
                lphr_q       <= sat2(bus.predict_i.lphr, bus.br_taken_i);
                lphr_index_q <= bus.predict_i.lphr_index;
            end
        end
    end

    assign bus.update_o     = {flush_q, br_target_q, pc_q, br_type_q, br_taken_q,
                               btb_update_q, lpht_update_q, lphr_q, lphr_index_q};
    assign bus.mispredict_o = flush_q;

`ifdef BPU_UPD_PERF_EN
    logic [31:0] perf_br_q;
    logic [31:0] perf_mis_q;

    // Event counters; deliberately untouched by the backend flush.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_br_q  <= '0;
            perf_mis_q <= '0;
        end else begin
            if (acc && bus.is_branch_i) begin
                perf_br_q <= perf_br_q + 32'd1;
            end
            if (acc && mis) begin
                perf_mis_q <= perf_mis_q + 32'd1;
            end
        end
    end

    assign bus.perf_br_cnt_o  = perf_br_q;
    assign bus.perf_mis_cnt_o = perf_mis_q;
`else
    assign bus.perf_br_cnt_o  = '0;
    assign bus.perf_mis_cnt_o = '0;
`endif

endmodule
